// File: rtl/ip_tile_arbiter_if.sv
// rtl/ip_tile_arbiter_if.sv - requester, response and tile-side signal bundle for ip_tile_arbiter
interface ip_tile_arbiter_if #(
  parameter int N_REQ         = 2,
  parameter int CSR_IN_WIDTH  = 16,
  parameter int CSR_OUT_WIDTH = 16,
  parameter int REG_WIDTH     = 32
);
  localparam int ID_W = $clog2(N_REQ);

  logic [N_REQ-1:0]              req_valid;
  logic [N_REQ-1:0]              req_ready;
  logic [N_REQ*CSR_IN_WIDTH-1:0] req_csr;
  logic [N_REQ*REG_WIDTH-1:0]    req_a;
  logic [N_REQ*REG_WIDTH-1:0]    req_b;

  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [ID_W-1:0]          rsp_id;
  logic [CSR_OUT_WIDTH-1:0] rsp_csr;
  logic [REG_WIDTH-1:0]     rsp_data;
  logic                     rsp_err;

  logic [CSR_IN_WIDTH-1:0]  tile_csr_in;
  logic                     tile_csr_in_re;
  logic [REG_WIDTH-1:0]     tile_data_reg_a;
  logic [REG_WIDTH-1:0]     tile_data_reg_b;
  logic [CSR_OUT_WIDTH-1:0] tile_csr_out;
  logic                     tile_csr_out_we;
  logic [REG_WIDTH-1:0]     tile_data_reg_c;

  modport master (
    input  req_valid, req_csr, req_a, req_b, rsp_ready,
    input  tile_csr_out, tile_csr_out_we, tile_data_reg_c,
    output req_ready, rsp_valid, rsp_id, rsp_csr, rsp_data, rsp_err,
    output tile_csr_in, tile_csr_in_re, tile_data_reg_a, tile_data_reg_b
  );

  modport slave (
    output req_valid, req_csr, req_a, req_b, rsp_ready,
    output tile_csr_out, tile_csr_out_we, tile_data_reg_c,
    input  req_ready, rsp_valid, rsp_id, rsp_csr, rsp_data, rsp_err,
    input  tile_csr_in, tile_csr_in_re, tile_data_reg_a, tile_data_reg_b
  );
endinterface

// File: rtl/ip_tile_arbiter.sv
// rtl/ip_tile_arbiter.sv - round-robin sharing of one ip_tile among N_REQ requesters
// One command in flight at a time; a watchdog aborts a tile that never strobes completion.
module ip_tile_arbiter #(
  parameter int N_REQ          = 2,
  parameter int CSR_IN_WIDTH   = 16,
  parameter int CSR_OUT_WIDTH  = 16,
  parameter int REG_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input logic               clk,
  input logic               arst_n,
  ip_tile_arbiter_if.master bus
);
  localparam int ID_W  = $clog2(N_REQ);
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t                   state_q, state_d;
  logic [TMR_W-1:0]         timer_q, timer_d, timer_inc;
  logic [ID_W-1:0]          last_grant_q, last_grant_d;
  logic [ID_W-1:0]          owner_q, owner_d;
  logic [CSR_IN_WIDTH-1:0]  csr_in_q, csr_in_d;
  logic [REG_WIDTH-1:0]     a_q, a_d, b_q, b_d;
  logic [CSR_OUT_WIDTH-1:0] rsp_csr_q, rsp_csr_d;
  logic [REG_WIDTH-1:0]     rsp_data_q, rsp_data_d;
  logic                     rsp_err_q, rsp_err_d;

  logic                     found;
  logic [ID_W-1:0]          grant;
  logic [N_REQ-1:0]         req_ready;
  logic                     csr_in_re;

  // Search starts just after the last served requester so every valid one is reached within N_REQ grants.
  always_comb begin
    int idx;
    found = 1'b0;
    grant = last_grant_q;
    idx   = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(last_grant_q) + k) % N_REQ;
      if (!found && bus.req_valid[idx]) begin
        found = 1'b1;
        grant = ID_W'(idx);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    csr_in_d     = csr_in_q;
    a_d          = a_q;
    b_d          = b_q;
    rsp_csr_d    = rsp_csr_q;
    rsp_data_d   = rsp_data_q;
    rsp_err_d    = rsp_err_q;
    req_ready    = '0;
    csr_in_re    = 1'b0;
    timer_inc    = timer_q + 1'b1;

    unique case (state_q)
      S_IDLE: begin
        if (found) begin
          req_ready[grant] = 1'b1;
          csr_in_d = bus.req_csr[int'(grant)*CSR_IN_WIDTH +: CSR_IN_WIDTH];
          a_d      = bus.req_a[int'(grant)*REG_WIDTH +: REG_WIDTH];
          b_d      = bus.req_b[int'(grant)*REG_WIDTH +: REG_WIDTH];
          owner_d  = grant;
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        csr_in_re = 1'b1;
        timer_d   = '0;
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        // A strobe arriving on the last allowed cycle still counts as a real completion.
        if (bus.tile_csr_out_we) begin
          rsp_csr_d  = bus.tile_csr_out;
          rsp_data_d = bus.tile_data_reg_c;
          rsp_err_d  = 1'b0;
          state_d    = S_RESP;
        end else if (timer_inc == TMR_LAST) begin
          rsp_csr_d  = '0;
          rsp_data_d = '0;
          rsp_err_d  = 1'b1;
          state_d    = S_RESP;
        end else begin
          timer_d = timer_inc;
        end
      end
      S_RESP: begin
        if (bus.rsp_ready) begin
          last_grant_d = owner_q;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q      <= S_IDLE;
      timer_q      <= '0;
      last_grant_q <= ID_W'(N_REQ - 1);
      owner_q      <= '0;
      csr_in_q     <= '0;
      a_q          <= '0;
      b_q          <= '0;
      rsp_csr_q    <= '0;
      rsp_data_q   <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      csr_in_q     <= csr_in_d;
      a_q          <= a_d;
      b_q          <= b_d;
      rsp_csr_q    <= rsp_csr_d;
      rsp_data_q   <= rsp_data_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  assign bus.req_ready       = req_ready;
  assign bus.rsp_valid       = (state_q == S_RESP);
  assign bus.rsp_id          = owner_q;
  assign bus.rsp_csr         = rsp_csr_q;
  assign bus.rsp_data        = rsp_data_q;
  assign bus.rsp_err         = rsp_err_q;
  assign bus.tile_csr_in     = csr_in_q;
  assign bus.tile_csr_in_re  = csr_in_re;
  assign bus.tile_data_reg_a = a_q;
  assign bus.tile_data_reg_b = b_q;
endmodule

// File: tb/tb_ip_tile_arbiter.sv
// tb/tb_ip_tile_arbiter.sv - vector table, corner sequences and random traffic against a reference model
module tb_ip_tile_arbiter;
  localparam int N  = 2;
  localparam int CW = 16;
  localparam int RW = 32;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic arst_n;
  always #5 clk = ~clk;

  ip_tile_arbiter_if #(.N_REQ(N), .CSR_IN_WIDTH(CW), .CSR_OUT_WIDTH(CW), .REG_WIDTH(RW)) bus ();

  ip_tile_arbiter #(
    .N_REQ(N), .CSR_IN_WIDTH(CW), .CSR_OUT_WIDTH(CW), .REG_WIDTH(RW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .arst_n(arst_n),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;
  int model_last;

  // Tile model: strobes tile_lat cycles after the re pulse with c=a+b, csr_out=rotate-right(csr_in).
  int          tile_lat = 1;
  int          cnt = 0;
  logic        we_a = 1'b0;
  logic [RW-1:0] c_a = '0;
  logic [CW-1:0] csr_a = '0;
  logic        man_we = 1'b0;
  logic [RW-1:0] man_c = '0;
  logic [CW-1:0] man_csr = '0;

  assign bus.tile_csr_out_we = man_we | we_a;
  assign bus.tile_data_reg_c = man_we ? man_c : c_a;
  assign bus.tile_csr_out    = man_we ? man_csr : csr_a;

  always @(negedge clk) begin
    if (!arst_n) begin
      cnt  <= 0;
      we_a <= 1'b0;
    end else begin
      we_a <= (cnt == 1);
      if (cnt == 1) begin
        c_a   <= bus.tile_data_reg_a + bus.tile_data_reg_b;
        csr_a <= {bus.tile_csr_in[0], bus.tile_csr_in[CW-1:1]};
      end
      if (cnt != 0) cnt <= cnt - 1;
      else if (bus.tile_csr_in_re) cnt <= tile_lat;
    end
  end

  typedef struct {
    logic [1:0]    mask;
    logic [CW-1:0] csr0, csr1;
    logic [RW-1:0] a0, a1, b0, b1;
    int            lat, rdly;
    bit            s_iss, s_rsp;
    int            exp_id;
    bit            exp_err;
    int            exp_wait;
  } vec_t;

  vec_t tbl [11];

  function automatic vec_t mk(logic [1:0] mask, logic [CW-1:0] csr0, logic [RW-1:0] a0, logic [RW-1:0] b0,
                              logic [CW-1:0] csr1, logic [RW-1:0] a1, logic [RW-1:0] b1,
                              int lat, int rdly, bit s_iss, bit s_rsp, int exp_id, bit exp_err, int exp_wait);
    vec_t v;
    v.mask = mask; v.csr0 = csr0; v.a0 = a0; v.b0 = b0; v.csr1 = csr1; v.a1 = a1; v.b1 = b1;
    v.lat = lat; v.rdly = rdly; v.s_iss = s_iss; v.s_rsp = s_rsp;
    v.exp_id = exp_id; v.exp_err = exp_err; v.exp_wait = exp_wait;
    return v;
  endfunction

  function automatic logic [CW-1:0] rot(logic [CW-1:0] x);
    return {x[0], x[CW-1:1]};
  endfunction

  function automatic int rr_pick(int last, logic [1:0] mask);
    for (int k = 1; k <= N; k++) begin
      if (mask[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic run_vec(vec_t v);
    logic [CW-1:0] csr_s;
    logic [RW-1:0] a_s, b_s, exp_data;
    logic [CW-1:0] exp_csr;
    logic [1:0]    exp_ready;
    int            waited;
    csr_s = (v.exp_id == 1) ? v.csr1 : v.csr0;
    a_s   = (v.exp_id == 1) ? v.a1 : v.a0;
    b_s   = (v.exp_id == 1) ? v.b1 : v.b0;
    exp_data = v.exp_err ? '0 : a_s + b_s;
    exp_csr  = v.exp_err ? '0 : rot(csr_s);

    @(negedge clk);
    bus.req_valid = v.mask;
    bus.req_csr   = {v.csr1, v.csr0};
    bus.req_a     = {v.a1, v.a0};
    bus.req_b     = {v.b1, v.b0};
    tile_lat      = v.lat;
    #1;
    exp_ready = (v.mask == 2'b00) ? 2'b00 : (2'b01 << v.exp_id);
    chk("req_ready", bus.req_ready, exp_ready);
    if (v.mask == 2'b00) begin
      @(negedge clk);
      chk("idle_no_re", bus.tile_csr_in_re, 1'b0);
      return;
    end

    @(negedge clk);
    chk("issue_re", bus.tile_csr_in_re, 1'b1);
    chk("tile_csr_in", bus.tile_csr_in, csr_s);
    chk("tile_a", bus.tile_data_reg_a, a_s);
    chk("tile_b", bus.tile_data_reg_b, b_s);
    bus.req_valid = '0;
    if (v.s_iss) begin
      man_we  = 1'b1;
      man_c   = 32'h1234_5678;
      man_csr = 16'h5A5A;
    end

    waited = 0;
    while (!bus.rsp_valid && waited < 40) begin
      @(negedge clk);
      man_we = 1'b0;
      waited++;
    end
    chk("rsp_latency", waited, v.exp_wait);
    chk("rsp_valid", bus.rsp_valid, 1'b1);
    chk("rsp_id", bus.rsp_id, v.exp_id);
    chk("rsp_err", bus.rsp_err, v.exp_err);
    chk("rsp_data", bus.rsp_data, exp_data);
    chk("rsp_csr", bus.rsp_csr, exp_csr);

    for (int d = 0; d < v.rdly; d++) begin
      bus.req_valid = 2'b11;
      #1;
      chk("hold_req_ready", bus.req_ready, 2'b00);
      chk("hold_rsp_valid", bus.rsp_valid, 1'b1);
      chk("hold_rsp_data", bus.rsp_data, exp_data);
      chk("hold_rsp_csr", bus.rsp_csr, exp_csr);
      if (d == 0 && v.s_rsp) begin
        man_we  = 1'b1;
        man_c   = 32'hBAD0_BAD0;
        man_csr = 16'hBAD0;
      end
      @(negedge clk);
      man_we = 1'b0;
    end

    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    bus.req_valid = '0;
    #1;
    chk("rsp_released", bus.rsp_valid, 1'b0);
    model_last = v.exp_id;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    vec_t v;
    arst_n        = 1'b0;
    bus.req_valid = '0;
    bus.req_csr   = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b0;

    tbl[0]  = mk(2'b01, 16'h0001, 32'd5, 32'd7, 16'hFFFF, 32'd99, 32'd1, 3, 0, 0, 0, 0, 0, 4);
    tbl[1]  = mk(2'b11, 16'h0010, 32'd1, 32'd2, 16'h0020, 32'd10, 32'd20, 1, 0, 0, 0, 1, 0, 2);
    tbl[2]  = mk(2'b11, 16'h0030, 32'd3, 32'd4, 16'h0040, 32'd30, 32'd40, 1, 0, 0, 0, 0, 0, 2);
    tbl[3]  = mk(2'b11, 16'h0050, 32'd5, 32'd6, 16'h0060, 32'd50, 32'd60, 2, 1, 0, 0, 1, 0, 3);
    tbl[4]  = mk(2'b11, 16'h0070, 32'd7, 32'd8, 16'h0080, 32'd70, 32'd80, 1, 0, 0, 0, 0, 0, 2);
    tbl[5]  = mk(2'b10, 16'h1111, 32'd1, 32'd1, 16'h2222, 32'd2, 32'd2, 0, 0, 0, 0, 1, 1, TO);
    tbl[6]  = mk(2'b01, 16'h0F0F, 32'd100, 32'd23, 16'h0, 32'd0, 32'd0, 7, 0, 0, 0, 0, 0, 8);
    tbl[7]  = mk(2'b10, 16'h0, 32'd0, 32'd0, 16'hABCD, 32'h1000, 32'h0234, 1, 10, 0, 1, 1, 0, 2);
    tbl[8]  = mk(2'b01, 16'h0003, 32'hDEAD_0000, 32'h0000_BEEF, 16'h0, 32'd0, 32'd0, 2, 0, 1, 0, 0, 0, 3);
    tbl[9]  = mk(2'b01, 16'h8000, 32'hFFFF_FFFF, 32'd1, 16'h0, 32'd0, 32'd0, 1, 0, 0, 0, 0, 0, 2);
    tbl[10] = mk(2'b00, 16'h0, 32'd0, 32'd0, 16'h0, 32'd0, 32'd0, 1, 0, 0, 0, -1, 0, 0);

    repeat (3) @(negedge clk);
    chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
    chk("rst_re", bus.tile_csr_in_re, 1'b0);
    chk("rst_req_ready", bus.req_ready, 2'b00);
    chk("rst_rsp_err", bus.rsp_err, 1'b0);
    chk("rst_rsp_data", bus.rsp_data, 32'd0);
    chk("rst_rsp_csr", bus.rsp_csr, 16'd0);
    chk("rst_rsp_id", bus.rsp_id, 1'b0);
    chk("rst_tile_csr_in", bus.tile_csr_in, 16'd0);
    chk("rst_tile_a", bus.tile_data_reg_a, 32'd0);
    chk("rst_tile_b", bus.tile_data_reg_b, 32'd0);
    arst_n = 1'b1;
    model_last = N - 1;

    for (int i = 0; i < 11; i++) run_vec(tbl[i]);

    // Abort a transaction in WAIT with an asynchronous reset, then confirm requester 0 regains priority.
    @(negedge clk);
    bus.req_valid = 2'b10;
    bus.req_csr   = {16'h7777, 16'h0};
    bus.req_a     = {32'h55, 32'h0};
    bus.req_b     = {32'h66, 32'h0};
    tile_lat      = 0;
    @(negedge clk);
    chk("rstwait_re", bus.tile_csr_in_re, 1'b1);
    bus.req_valid = '0;
    repeat (3) @(negedge clk);
    chk("rstwait_no_rsp", bus.rsp_valid, 1'b0);
    #2 arst_n = 1'b0;
    #1;
    chk("arst_re", bus.tile_csr_in_re, 1'b0);
    chk("arst_rsp_valid", bus.rsp_valid, 1'b0);
    chk("arst_rsp_id", bus.rsp_id, 1'b0);
    chk("arst_tile_csr_in", bus.tile_csr_in, 16'd0);
    chk("arst_tile_a", bus.tile_data_reg_a, 32'd0);
    chk("arst_tile_b", bus.tile_data_reg_b, 32'd0);
    @(negedge clk);
    @(negedge clk);
    arst_n = 1'b1;
    model_last = N - 1;
    run_vec(mk(2'b11, 16'h0101, 32'd9, 32'd9, 16'h0202, 32'd8, 32'd8, 1, 0, 0, 0, 0, 0, 2));

    for (int t = 0; t < 60; t++) begin
      v.mask  = 2'($urandom_range(0, 3));
      v.csr0  = 16'($urandom);
      v.csr1  = 16'($urandom);
      v.a0    = $urandom;
      v.a1    = $urandom;
      v.b0    = $urandom;
      v.b1    = $urandom;
      v.lat   = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 7));
      v.rdly  = int'($urandom_range(0, 3));
      v.s_iss = 1'b0;
      v.s_rsp = 1'b0;
      v.exp_id   = rr_pick(model_last, v.mask);
      v.exp_err  = (v.lat == 0);
      v.exp_wait = (v.lat == 0) ? TO : v.lat + 1;
      run_vec(v);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
